// File: rtl/fifo_read_port.sv
// Read side of an async FIFO: Gray/binary read pointer, empty flag, word count,
// and a 2-entry registered output stage that presents a valid/ready stream.
module fifo_read_port #(
  parameter int unsigned DATASIZE = 128,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rwords,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0]       rbin;
  logic [PW-1:0]       rbinnext;
  logic [PW-1:0]       rgraynext;
  logic [PW-1:0]       wbin_c;
  logic [1:0]          count;
  logic [1:0]          count_next;
  logic [DATASIZE-1:0] stage1;
  logic                fetch_c;
  logic                pop_c;

  assign raddr = rbin[ADDRSIZE-1:0];

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    wbin_c = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wbin_c[i] = ^(rq2_wptr >> i);
    end
  end

  // Fetch decision looks only at registered state, so a pop never frees a slot the same cycle.
  always_comb begin
    fetch_c    = !rempty && (count != 2'd2);
    pop_c      = dout_valid && dout_ready;
    rbinnext   = rbin + PW'(fetch_c);
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
    count_next = count + 2'(fetch_c) - 2'(pop_c);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin       <= '0;
      rptr       <= '0;
      // Pointer restarts at zero, so emptiness follows the write pointer directly.
      rempty     <= (rq2_wptr == '0);
      rwords     <= '0;
      count      <= 2'd0;
      dout_valid <= 1'b0;
      dout       <= '0;
      stage1     <= '0;
    end else begin
      rbin       <= rbinnext;
      rptr       <= rgraynext;
      rempty     <= (rgraynext == rq2_wptr);
      rwords     <= wbin_c - rbinnext;
      count      <= count_next;
      dout_valid <= (count_next != 2'd0);
      if (pop_c) begin
        if (fetch_c && (count == 2'd1)) begin
          dout <= rdata_mem;
        end else begin
          dout <= stage1;
        end
      end else if (fetch_c) begin
        if (count == 2'd0) begin
          dout <= rdata_mem;
        end else begin
          stage1 <= rdata_mem;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_port.sv
// Bench for fifo_read_port: memory/writer model, cycle-level reference of the
// read side, and a data scoreboard fed by writes and drained by handshakes.
module tb_fifo_read_port;

  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 4;
  localparam int unsigned PW    = AW + 1;
  localparam int          DEPTH = 16;
  localparam int          PMOD  = 32;

  logic          rclk;
  logic          rrst;
  logic [PW-1:0] rq2_wptr;
  logic [DW-1:0] rdata_mem;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic [PW-1:0] rwords;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  fifo_read_port #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rdata_mem(rdata_mem),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .rwords(rwords),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  logic [DW-1:0] mem [DEPTH];
  assign rdata_mem = mem[raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int tests;
  int fails;
  int wcnt;
  int popped;
  logic [DW-1:0] hist[$];
  logic [DW-1:0] sbq[$];

  int            m_rd;
  logic [DW-1:0] m_stage[$];
  logic          m_rempty;
  logic [PW-1:0] m_rwords;
  logic [PW-1:0] m_rptr;
  logic [AW-1:0] prev_raddr;
  logic          saw_wrap;

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic int g2b(input logic [PW-1:0] g);
    int r;
    r = 0;
    for (int i = PW - 1; i >= 0; i--) r = r * 2 + ((r % 2) ^ int'(g[i]));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare against the reference, then consume handshakes, then advance the reference.
  always @(negedge rclk) begin : monitor
    logic pop;
    logic fetch;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    chk("dout_valid", DW'(dout_valid), DW'(m_stage.size() > 0));
    if (m_stage.size() > 0) chk("dout", dout, m_stage[0]);
    chk("rempty", DW'(rempty), DW'(m_rempty));
    chk("rwords", DW'(rwords), DW'(m_rwords));
    chk("rptr", DW'(rptr), DW'(m_rptr));
    chk("raddr", DW'(raddr), DW'(m_rd % DEPTH));
    if (prev_raddr == AW'(DEPTH - 1) && raddr == '0) saw_wrap = 1'b1;
    prev_raddr = raddr;

    if (!rrst && dout_valid && dout_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", DW'(1), DW'(0));
      end else begin
        exp_d = sbq.pop_front();
        chk("sb_data", dout, exp_d);
        popped++;
      end
    end

    if (rrst) begin
      m_rd = 0;
      m_stage.delete();
      m_rptr = '0;
      m_rempty = (rq2_wptr == '0);
      m_rwords = '0;
    end else begin
      pop   = (m_stage.size() > 0) && dout_ready;
      fetch = !m_rempty && (m_stage.size() < 2);
      d     = mem[m_rd % DEPTH];
      if (pop) void'(m_stage.pop_front());
      if (fetch) begin
        m_stage.push_back(d);
        m_rd = (m_rd + 1) % PMOD;
      end
      m_rptr   = gray(m_rd);
      m_rempty = (m_rptr == rq2_wptr);
      m_rwords = PW'(g2b(rq2_wptr) - m_rd);
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic put_word(input logic [DW-1:0] w);
    mem[wcnt % DEPTH] = w;
    hist.push_back(w);
    sbq.push_back(w);
    wcnt++;
    rq2_wptr = gray(wcnt % PMOD);
  endtask

  // Writer never overruns words the reader has not yet handed downstream.
  task automatic write_words(input int n);
    for (int k = 0; k < n; k++) begin
      if (wcnt - popped < DEPTH) put_word({$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  task automatic full_reset();
    rrst = 1'b1;
    wcnt = 0;
    popped = 0;
    sbq.delete();
    hist.delete();
    rq2_wptr = '0;
    step();
    step();
    rrst = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    dout_ready = 1'b1;
    while ((sbq.size() != 0 || dout_valid) && n < budget) begin
      step();
      n++;
    end
    chk(nm, DW'(sbq.size()), DW'(0));
  endtask

  initial begin
    tests = 0; fails = 0; wcnt = 0; popped = 0;
    m_rd = 0; m_rempty = 1'b1; m_rwords = '0; m_rptr = '0;
    prev_raddr = '0; saw_wrap = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rrst = 1'b1; rq2_wptr = '0; dout_ready = 1'b0;

    full_reset();
    chk("rst_dout", dout, DW'(0));
    chk("rst_raddr", DW'(raddr), DW'(0));

    // Single word
    dout_ready = 1'b1;
    put_word(DW'(8'hA5));
    step();
    chk("single_rempty", DW'(rempty), DW'(0));
    chk("single_rwords", DW'(rwords), DW'(1));
    step();
    chk("single_valid", DW'(dout_valid), DW'(1));
    chk("single_dout", dout, DW'(8'hA5));
    chk("single_rptr", DW'(rptr), DW'(5'b00001));
    drain("single_drain", 20);

    // Backpressure with five words
    dout_ready = 1'b0;
    full_reset();
    write_words(5);
    for (int i = 0; i < 6; i++) step();
    chk("bp_rwords", DW'(rwords), DW'(3));
    chk("bp_dout", dout, hist[0]);
    drain("bp_drain", 40);

    // Reset while the output stage is full and the write pointer is non-zero
    dout_ready = 1'b0;
    write_words(4);
    for (int i = 0; i < 4; i++) step();
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    chk("mid_rst_valid", DW'(dout_valid), DW'(0));
    chk("mid_rst_raddr", DW'(raddr), DW'(0));
    sbq = hist;
    popped = 0;
    drain("mid_rst_drain", 60);

    // Wrap: 40 words streamed
    full_reset();
    dout_ready = 1'b1;
    saw_wrap = 1'b0;
    for (int n = 0; n < 300 && wcnt < 40; n++) begin
      write_words($urandom_range(1, 2));
      step();
    end
    drain("wrap_drain", 100);
    chk("wrap_words", DW'(wcnt), DW'(40));
    chk("wrap_raddr", DW'(saw_wrap), DW'(1));

    // Random traffic with multi-word pointer jumps
    full_reset();
    for (int n = 0; n < 3000; n++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) write_words($urandom_range(0, 5));
      step();
    end
    drain("rand_drain", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
